rbcp_regbank: RTL

- Parametrised RBCP slave register bank: the next generation of the fixed 6-byte RBCP command decoder.
- Holds NUM_REGS 32-bit configuration words and one self-clearing trigger byte; the optional feature adds a read-only status bank.
- Sits between the SiTCP RBCP interface (we/re/wd/addr/rd/ack) and the acquisition core.
- Each access gets exactly one registered ack pulse.

---
 rtl/rbcp_regbank.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rbcp_regbank.sv
// rbcp_regbank -- RBCP slave register bank for the acquisition core.
//
// Decodes SiTCP RBCP byte accesses into NUM_REGS big-endian 32-bit config
// words, one self-clearing trigger byte and, when RBCP_STATUS_EN is defined,
// a read-only bank of NUM_STAT status words read through a per-word snapshot.
// Every strobe is answered by exactly one registered ack pulse.
//
// Optional feature macro: RBCP_STATUS_EN (adds stat_in and the status bank).
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   cfg_regs     config words, word k at [32k+31:32k]
//   trig         trigger pulses, each TRIG_LEN cycles long
//   stat_in      status words (RBCP_STATUS_EN only)
//   we, re       single-cycle write / read strobes
//   wd, addr     write data, byte address
//   rd           read data, valid while ack=1, held otherwise
//   ack          one-cycle acknowledge
//   addr_err     one-cycle pulse with ack for an unmapped address
module rbcp_regbank #(
  parameter logic [31:0]            BASE_ADDR = 32'h0000_0000,
  parameter int unsigned            NUM_REGS  = 2,
  parameter logic [NUM_REGS*32-1:0] CFG_INIT  = '0,
  parameter int unsigned            TRIG_BITS = 8,
  parameter int unsigned            TRIG_LEN  = 4,
  parameter int unsigned            NUM_STAT  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [NUM_REGS*32-1:0]   cfg_regs,
  output logic [TRIG_BITS-1:0]     trig,
`ifdef RBCP_STATUS_EN
  input  logic [NUM_STAT*32-1:0]   stat_in,
`endif
  input  logic                     we,
  input  logic                     re,
  input  logic [7:0]               wd,
  input  logic [31:0]              addr,
  output logic [7:0]               rd,
  output logic                     ack,
  output logic                     addr_err
);

  if (NUM_REGS < 1 || NUM_REGS > 16 || TRIG_BITS < 1 || TRIG_BITS > 8 ||
      TRIG_LEN < 1 || NUM_STAT < 1) begin : g_bad_params
    $error("rbcp_regbank: parameter out of range");
  end

  localparam logic [31:0]   TRIG_OFF = 32'(4 * NUM_REGS);
  localparam int unsigned   CW       = $clog2(TRIG_LEN + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TRIG_LEN);

  logic [31:0]   cfg_q [NUM_REGS];
  logic [31:0]   cfg_d [NUM_REGS];
  logic [CW-1:0] cnt_q [TRIG_BITS];
  logic [CW-1:0] cnt_d [TRIG_BITS];
  logic [7:0]    rd_q, rd_d;
  logic          ack_q, err_q;
`ifdef RBCP_STATUS_EN
  logic [31:0]   snap_q [NUM_STAT];
  logic [31:0]   snap_d [NUM_STAT];
`endif

  logic [31:0] off;
  logic        hit;
  logic [7:0]  rmux;
  logic        rd_go, wr_go;

  // Offset wraps for addr < BASE_ADDR, landing far outside the map.
  assign off   = addr - BASE_ADDR;
  // A simultaneous read wins; the write half is discarded.
  assign rd_go = re;
  assign wr_go = we & ~re;

  // Address decode and read-data mux; rmux stays zero for unmapped offsets.
  always_comb begin
    hit  = 1'b0;
    rmux = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (off == 32'(4 * k + b)) begin
          hit  = 1'b1;
          rmux = cfg_q[k][8*(3-b) +: 8];
        end
      end
    end
    if (off == TRIG_OFF) begin
      hit                  = 1'b1;
      rmux[TRIG_BITS-1:0]  = trig;
    end
`ifdef RBCP_STATUS_EN
    // MSB byte comes live (it is captured at the same edge); the other bytes
    // come from the snapshot so a 4-byte read sequence is coherent.
    for (int unsigned j = 0; j < NUM_STAT; j++) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (off == TRIG_OFF + 32'(1 + 4 * j + b)) begin
          hit = 1'b1;
          if (b == 0) rmux = stat_in[32*j+24 +: 8];
          else        rmux = snap_q[j][8*(3-b) +: 8];
        end
      end
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    cfg_d = cfg_q;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_go && off == 32'(4 * k + b)) cfg_d[k][8*(3-b) +: 8] = wd;
      end
    end

    // Reload takes priority over the countdown, so a rewrite extends a pulse.
    for (int unsigned i = 0; i < TRIG_BITS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (wr_go && off == TRIG_OFF && wd[i]) cnt_d[i] = CNT_LOAD;
      else if (cnt_q[i] != '0)               cnt_d[i] = cnt_q[i] - CW'(1);
    end

    rd_d = rd_q;
    if (rd_go) rd_d = rmux;

`ifdef RBCP_STATUS_EN
    snap_d = snap_q;
    for (int unsigned j = 0; j < NUM_STAT; j++) begin
      if (rd_go && off == TRIG_OFF + 32'(1 + 4 * j)) snap_d[j] = stat_in[32*j +: 32];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) cfg_q[k] <= CFG_INIT[32*k +: 32];
      for (int unsigned i = 0; i < TRIG_BITS; i++) cnt_q[i] <= '0;
`ifdef RBCP_STATUS_EN
      for (int unsigned j = 0; j < NUM_STAT; j++) snap_q[j] <= '0;
`endif
      rd_q  <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
`ifdef RBCP_STATUS_EN
      snap_q <= snap_d;
`endif
      rd_q  <= rd_d;
      ack_q <= re | we;
      err_q <= (re | we) & ~hit;
    end
  end

  always_comb begin
    cfg_regs = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) cfg_regs[32*k +: 32] = cfg_q[k];
    trig = '0;
    for (int unsigned i = 0; i < TRIG_BITS; i++) trig[i] = (cnt_q[i] != '0);
  end

  assign rd       = rd_q;
  assign ack      = ack_q;
  assign addr_err = err_q;

endmodule
